// File: rtl/edfic_nest_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : edfic_nest_ctrl
// Purpose  : Preemption and nesting controller between the EDF interrupt
//            controller and one hart. Keeps a stack of the absolute deadlines
//            of the running handlers. It offers the arbitration winner to the
//            core only when the winner's deadline is strictly earlier than the
//            running handler's deadline. It claims the line back at the
//            controller when the core accepts.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   mtime_i                 platform time (low DlWidth bits used as "now")
//   irq_valid_i/id_i/dl_i   controller winner (relative deadline)
//   edfic_ack_o/edfic_id_o  claim pulse and claimed id back to the controller
//   core_irq_o/core_id_o    interrupt offer to the core
//   core_ack_i              core accepts the offer (honoured only while offered)
//   core_done_i             current handler finished (pops the stack)
//   nest_depth_o            number of running handlers
//   stack_full_o            nest_depth_o == StackDepth
//   deadline_miss_o         one-cycle pulse when the running top goes overdue
//   miss_cnt_o              saturating count of deadline misses
// Build option
//   EDFIC_NEST_OVERRUN_EN   enables overrun detection. When it is undefined,
//                           deadline_miss_o and miss_cnt_o are tied to 0.
// ============================================================================
module edfic_nest_ctrl #(
  parameter int NrIrqs     = 4,
  parameter int TsWidth    = 24,
  parameter int TsClip     = 0,
  parameter int StackDepth = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [63:0]                       mtime_i,
  input  logic                              irq_valid_i,
  input  logic [$clog2(NrIrqs)-1:0]         irq_id_i,
  input  logic [TsWidth+TsClip-1:0]         irq_dl_i,
  output logic                              edfic_ack_o,
  output logic [$clog2(NrIrqs)-1:0]         edfic_id_o,
  output logic                              core_irq_o,
  output logic [$clog2(NrIrqs)-1:0]         core_id_o,
  input  logic                              core_ack_i,
  input  logic                              core_done_i,
  output logic [$clog2(StackDepth+1)-1:0]   nest_depth_o,
  output logic                              stack_full_o,
  output logic                              deadline_miss_o,
  output logic [15:0]                       miss_cnt_o
);

  localparam int IdWidth    = $clog2(NrIrqs);
  localparam int DlWidth    = TsWidth + TsClip;
  localparam int DepthWidth = $clog2(StackDepth + 1);
  localparam int IdxWidth   = (StackDepth > 1) ? $clog2(StackDepth) : 1;

  localparam logic [DepthWidth-1:0] c_DEPTH_MAX = DepthWidth'(StackDepth);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OFFER = 2'd1;
  localparam logic [1:0] ST_CLAIM = 2'd2;

  logic [1:0]            r_state;
  logic [IdWidth-1:0]    r_off_id;
  logic [DlWidth-1:0]    r_off_abs;
  logic                  r_edfic_ack;
  logic [IdWidth-1:0]    r_edfic_id;
  logic [DepthWidth-1:0] r_depth;
  logic [DlWidth-1:0]    r_stk_dl [StackDepth];
  logic [IdWidth-1:0]    r_stk_id [StackDepth];

  logic [DlWidth-1:0]    w_now;
  logic [DepthWidth-1:0] w_depth_m1;
  logic [IdxWidth-1:0]   w_top_idx;
  logic [IdxWidth-1:0]   w_push_idx;
  logic [IdxWidth-1:0]   w_wr_idx;
  logic [DlWidth-1:0]    w_top_rel;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_eligible;
  logic                  w_ack;
  logic                  w_pop;

  assign w_now      = mtime_i[DlWidth-1:0];
  assign w_empty    = (r_depth == '0);
  assign w_full     = (r_depth == c_DEPTH_MAX);
  assign w_depth_m1 = r_depth - DepthWidth'(1);
  // An empty stack points at slot 0 so the read index never leaves the array.
  assign w_top_idx  = w_empty ? '0 : w_depth_m1[IdxWidth-1:0];
  assign w_push_idx = r_depth[IdxWidth-1:0];
  assign w_top_rel  = r_stk_dl[w_top_idx] - w_now;

  // Equal deadlines do not preempt: the comparison is strict.
  assign w_eligible = irq_valid_i & ~w_full &
                      (w_empty | ($signed(irq_dl_i) < $signed(w_top_rel)));

  assign w_ack = core_ack_i & (r_state == ST_OFFER);
  assign w_pop = core_done_i & ~w_empty;
  // When a pop and a push happen together, the new entry replaces the top.
  assign w_wr_idx = w_pop ? w_top_idx : w_push_idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_off_id    <= '0;
      r_off_abs   <= '0;
      r_edfic_ack <= 1'b0;
      r_edfic_id  <= '0;
      r_depth     <= '0;
      for (int i = 0; i < StackDepth; i++) begin
        r_stk_dl[i] <= '0;
        r_stk_id[i] <= '0;
      end
    end else begin
      r_edfic_ack <= w_ack;
      if (w_ack) begin
        r_edfic_id <= r_off_id;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_eligible) begin
            r_off_id  <= irq_id_i;
            r_off_abs <= irq_dl_i + w_now;
            r_state   <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (w_ack) begin
            r_state <= ST_CLAIM;
          end else if (w_eligible) begin
            // A newer, earlier winner replaces the pending offer.
            r_off_id  <= irq_id_i;
            r_off_abs <= irq_dl_i + w_now;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CLAIM: begin
          // One quiet cycle lets the controller clear the pending bit.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      if (w_ack) begin
        r_stk_dl[w_wr_idx] <= r_off_abs;
        r_stk_id[w_wr_idx] <= r_off_id;
      end
      if (w_ack && !w_pop) begin
        r_depth <= r_depth + DepthWidth'(1);
      end else if (w_pop && !w_ack) begin
        r_depth <= w_depth_m1;
      end
    end
  end

  assign core_irq_o   = (r_state == ST_OFFER);
  assign core_id_o    = r_off_id;
  assign edfic_ack_o  = r_edfic_ack;
  assign edfic_id_o   = r_edfic_id;
  assign nest_depth_o = r_depth;
  assign stack_full_o = w_full;

`ifdef EDFIC_NEST_OVERRUN_EN
  logic        r_stk_miss [StackDepth];
  logic        r_miss_pulse;
  logic [15:0] r_miss_cnt;
  logic        w_overdue;

  assign w_overdue = ~w_empty & ~r_stk_miss[w_top_idx] & ($signed(w_top_rel) < 0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_miss_pulse <= 1'b0;
      r_miss_cnt   <= '0;
      for (int i = 0; i < StackDepth; i++) begin
        r_stk_miss[i] <= 1'b0;
      end
    end else begin
      r_miss_pulse <= w_overdue;
      if (w_overdue) begin
        r_stk_miss[w_top_idx] <= 1'b1;
        if (r_miss_cnt != 16'hFFFF) begin
          r_miss_cnt <= r_miss_cnt + 16'd1;
        end
      end
      // A freshly pushed entry starts unreported; this write comes last so it
      // wins over the mark above when the top is being replaced.
      if (w_ack) begin
        r_stk_miss[w_wr_idx] <= 1'b0;
      end
    end
  end

  assign deadline_miss_o = r_miss_pulse;
  assign miss_cnt_o      = r_miss_cnt;
`else
  assign deadline_miss_o = 1'b0;
  assign miss_cnt_o      = 16'd0;
`endif

  // Time bits above the deadline width are not used.
  generate
    if (DlWidth < 64) begin : g_mtime_unused
      logic w_unused_mtime;
      assign w_unused_mtime = ^mtime_i[63:DlWidth];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_edfic_nest_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_edfic_nest_ctrl
// Purpose  : Self-checking bench for edfic_nest_ctrl. It runs directed
//            scenarios and then randomized traffic. Each cycle the outputs are
//            compared against a queue-based reference model of the nesting
//            rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edfic_nest_ctrl;

  localparam int NI = 4;
  localparam int TW = 24;
  localparam int TC = 0;
  localparam int SD = 2;
  localparam int DL = TW + TC;
  localparam int IW = $clog2(NI);
  localparam int DW = $clog2(SD + 1);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [63:0]   mtime_i = '0;
  logic          irq_valid_i = 1'b0;
  logic [IW-1:0] irq_id_i = '0;
  logic [DL-1:0] irq_dl_i = '0;
  logic          edfic_ack_o;
  logic [IW-1:0] edfic_id_o;
  logic          core_irq_o;
  logic [IW-1:0] core_id_o;
  logic          core_ack_i = 1'b0;
  logic          core_done_i = 1'b0;
  logic [DW-1:0] nest_depth_o;
  logic          stack_full_o;
  logic          deadline_miss_o;
  logic [15:0]   miss_cnt_o;

  edfic_nest_ctrl #(
    .NrIrqs(NI), .TsWidth(TW), .TsClip(TC), .StackDepth(SD)
  ) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .mtime_i(mtime_i),
    .irq_valid_i(irq_valid_i), .irq_id_i(irq_id_i), .irq_dl_i(irq_dl_i),
    .edfic_ack_o(edfic_ack_o), .edfic_id_o(edfic_id_o),
    .core_irq_o(core_irq_o), .core_id_o(core_id_o),
    .core_ack_i(core_ack_i), .core_done_i(core_done_i),
    .nest_depth_o(nest_depth_o), .stack_full_o(stack_full_o),
    .deadline_miss_o(deadline_miss_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: running handlers as a queue (last element = top), plus
  // the pending offer and the claim gap.
  logic [DL-1:0] q_abs[$];
  logic [IW-1:0] q_id[$];
  logic          q_miss[$];
  logic          m_off, m_claim, m_eack, m_pulse;
  logic [IW-1:0] m_oid, m_eid;
  logic [DL-1:0] m_oabs;
  logic [15:0]   m_cnt;

  task automatic model_reset();
    q_abs.delete(); q_id.delete(); q_miss.delete();
    m_off = 0; m_claim = 0; m_eack = 0; m_pulse = 0;
    m_oid = '0; m_eid = '0; m_oabs = '0; m_cnt = '0;
  endtask

  task automatic model_step(input logic v, input logic [IW-1:0] id, input logic [DL-1:0] dl,
                            input logic a, input logic d, input logic [DL-1:0] now);
    int dep;
    logic [DL-1:0] rel;
    logic elig, ackh;
    dep  = q_abs.size();
    rel  = (dep > 0) ? q_abs[dep-1] - now : '0;
    elig = v && (dep < SD) && ((dep == 0) || ($signed(dl) < $signed(rel)));
    ackh = m_off && a;
    m_eack = ackh;
    if (ackh) m_eid = m_oid;
    m_pulse = 1'b0;
`ifdef EDFIC_NEST_OVERRUN_EN
    if (dep > 0 && !q_miss[dep-1] && $signed(rel) < 0) begin
      q_miss[dep-1] = 1'b1;
      m_pulse = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
`endif
    if (d && dep > 0) begin
      void'(q_abs.pop_back()); void'(q_id.pop_back()); void'(q_miss.pop_back());
    end
    if (ackh) begin
      q_abs.push_back(m_oabs); q_id.push_back(m_oid); q_miss.push_back(1'b0);
    end
    if (m_claim) begin
      m_claim = 1'b0;
    end else if (ackh) begin
      m_off = 1'b0; m_claim = 1'b1;
    end else if (elig) begin
      m_off = 1'b1; m_oid = id; m_oabs = dl + now;
    end else begin
      m_off = 1'b0;
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic v, input logic [IW-1:0] id, input logic [DL-1:0] dl,
                      input logic a, input logic d, input logic [63:0] mt, input logic r);
    rst_i = r; irq_valid_i = v; irq_id_i = id; irq_dl_i = dl;
    core_ack_i = a; core_done_i = d; mtime_i = mt;
    if (r) model_reset();
    else   model_step(v, id, dl, a, d, mt[DL-1:0]);
    @(posedge clk_i);
    #1;
    chk("core_irq", 64'(core_irq_o), 64'(m_off));
    if (m_off) chk("core_id", 64'(core_id_o), 64'(m_oid));
    chk("edfic_ack", 64'(edfic_ack_o), 64'(m_eack));
    if (m_eack) chk("edfic_id", 64'(edfic_id_o), 64'(m_eid));
    chk("depth", 64'(nest_depth_o), 64'(q_abs.size()));
    chk("full", 64'(stack_full_o), 64'(q_abs.size() == SD));
    chk("miss_pulse", 64'(deadline_miss_o), 64'(m_pulse));
    chk("miss_cnt", 64'(miss_cnt_o), 64'(m_cnt));
  endtask

  logic [63:0] mt;
  logic        v, a, d, r;

  initial begin
    model_reset();
    @(posedge clk_i); #1;
    step(0, 0, 0, 0, 0, 64'd0, 1);
    chk("rst_irq", 64'(core_irq_o), 64'd0);
    chk("rst_depth", 64'(nest_depth_o), 64'd0);

    // Single irq on an empty stack, then claim.
    step(1, 2, 24'd100, 0, 0, 64'd0, 0);
    chk("single_offer", 64'(core_irq_o), 64'd1);
    chk("single_id", 64'(core_id_o), 64'd2);
    step(1, 2, 24'd100, 1, 0, 64'd0, 0);
    chk("single_ack", 64'(edfic_ack_o), 64'd1);
    chk("single_eid", 64'(edfic_id_o), 64'd2);
    chk("single_depth", 64'(nest_depth_o), 64'd1);
    step(0, 0, 0, 0, 0, 64'd0, 0);
    chk("claim_gap", 64'(core_irq_o), 64'd0);

    // Preemption at mtime=10 against top_rel=90.
    step(1, 1, 24'd90, 0, 0, 64'd10, 0);
    chk("equal_blocks", 64'(core_irq_o), 64'd0);
    step(1, 1, 24'd89, 0, 0, 64'd10, 0);
    chk("earlier_offers", 64'(core_irq_o), 64'd1);
    step(0, 1, 24'd89, 0, 0, 64'd10, 0);
    chk("withdraw", 64'(core_irq_o), 64'd0);
    chk("withdraw_noack", 64'(edfic_ack_o), 64'd0);
    step(1, 1, 24'd50, 0, 0, 64'd10, 0);
    chk("offer_dl50", 64'(core_irq_o), 64'd1);
    step(1, 3, 24'd40, 0, 0, 64'd10, 0);
    chk("replace_id", 64'(core_id_o), 64'd3);
    step(1, 3, 24'd40, 1, 0, 64'd10, 0);
    chk("nest_eid", 64'(edfic_id_o), 64'd3);
    chk("nest_full", 64'(stack_full_o), 64'd1);

    // Full stack blocks; a pop re-enables the offer within two cycles.
    step(1, 0, 24'd1, 0, 0, 64'd10, 0);
    step(1, 0, 24'd1, 0, 0, 64'd10, 0);
    chk("full_blocks", 64'(core_irq_o), 64'd0);
    step(1, 0, 24'd1, 0, 1, 64'd10, 0);
    chk("pop_depth", 64'(nest_depth_o), 64'd1);
    step(1, 0, 24'd1, 0, 0, 64'd10, 0);
    chk("pop_reoffer", 64'(core_irq_o), 64'd1);

    // Wrap-around: abs deadline wraps to 20, top_rel = 40.
    step(0, 0, 0, 0, 0, 64'd0, 1);
    step(1, 1, 24'd40, 0, 0, 64'h00FF_FFEC, 0);
    step(1, 1, 24'd40, 1, 0, 64'h00FF_FFEC, 0);
    step(0, 0, 0, 0, 0, 64'h00FF_FFEC, 0);
    step(1, 2, 24'd40, 0, 0, 64'h00FF_FFEC, 0);
    chk("wrap_equal", 64'(core_irq_o), 64'd0);
    step(1, 2, 24'd30, 0, 0, 64'h00FF_FFEC, 0);
    chk("wrap_preempt", 64'(core_irq_o), 64'd1);

`ifdef EDFIC_NEST_OVERRUN_EN
    // Overrun: dl=5, time moves to 6 -> exactly one miss report.
    step(0, 0, 0, 0, 0, 64'd0, 1);
    step(1, 1, 24'd5, 0, 0, 64'd0, 0);
    step(1, 1, 24'd5, 1, 0, 64'd0, 0);
    step(0, 0, 0, 0, 0, 64'd0, 0);
    step(0, 0, 0, 0, 0, 64'd6, 0);
    chk("ovr_pulse", 64'(deadline_miss_o), 64'd1);
    chk("ovr_cnt", 64'(miss_cnt_o), 64'd1);
    step(0, 0, 0, 0, 0, 64'd7, 0);
    chk("ovr_once", 64'(deadline_miss_o), 64'd0);
    step(0, 0, 0, 0, 1, 64'd8, 0);
    chk("ovr_pop", 64'(nest_depth_o), 64'd0);
`endif

    // Randomized traffic crossing the time wrap point.
    step(0, 0, 0, 0, 0, 64'd0, 1);
    mt = 64'h00FF_FF00;
    for (int i = 0; i < 3000; i++) begin
      mt = mt + 64'($urandom_range(0, 3));
      v  = ($urandom_range(0, 2) != 0);
      a  = m_off ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      d  = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 199) == 0);
      step(v, IW'($urandom_range(0, NI - 1)), DL'($urandom_range(0, 200)), a, d, mt, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edfic_nest_ctrl.md
# edfic_nest_ctrl

Preemption and nesting controller between the EDF interrupt controller and one hart. Takes the arbitration winner (id, relative deadline) from the controller and keeps a stack of the absolute deadlines of the handlers currently running. It offers an interrupt to the core only if the winner's deadline is strictly earlier than the running handler's deadline. On core acceptance it claims the line back at the controller.

## Interface
- NrIrqs, 4: number of interrupt lines; IdWidth = $clog2(NrIrqs) (localparam).
- TsWidth, 24: stored timestamp width of the controller.
- TsClip, 0: timestamp clip of the controller; DlWidth = TsWidth + TsClip (localparam).
- StackDepth, 4: maximum nesting level (≥1); DepthWidth = $clog2(StackDepth+1) (localparam).

Clocking and reset:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; synchronous, active-high.

Controller side:
- mtime_i  in  64  platform time.
- irq_valid_i  in  1  controller has a pending, enabled winner.
- irq_id_i  in  IdWidth  winner id.
- irq_dl_i  in  DlWidth  winner deadline relative to now.
- edfic_ack_o  out  1  claim pulse to the controller's ack input.
- edfic_id_o  out  IdWidth  id claimed with edfic_ack_o.

Core side:
- core_irq_o  out  1  interrupt offered.
- core_id_o  out  IdWidth  offered id.
- core_ack_i  in  1  core takes the offer; honoured only while core_irq_o=1.
- core_done_i  in  1  current handler finished (mret).

Status:
- nest_depth_o  out  DepthWidth  running handlers.
- stack_full_o  out  1  nest_depth_o == StackDepth.
- deadline_miss_o  out  1  miss pulse (see Configuration).
- miss_cnt_o  out  16  saturating miss count (see Configuration).

## Operation
- now = mtime_i[DlWidth-1:0]. All deadline arithmetic is modulo 2^DlWidth. Comparisons are signed two's-complement over DlWidth bits. Live deadlines must stay within half the range of now.
- Stack entries hold {abs_dl, id, missed}. top_rel = stack[top].abs_dl − now.
- eligible = irq_valid_i & ~stack_full_o & (depth==0 | signed(irq_dl_i) < signed(top_rel)). An equal deadline does not preempt.
- State machine: IDLE, OFFER, CLAIM.
  - IDLE: if eligible, latch id=irq_id_i and abs = irq_dl_i + now, then go to OFFER.
  - OFFER: core_irq_o=1 and core_id_o=latched id.
    - core_ack_i=1: push {abs, id, 0}, set edfic_ack_o=1 and edfic_id_o=id, go to CLAIM.
    - Otherwise, if eligible, re-latch id and abs from the current inputs (a newer, earlier winner replaces the offer) and stay in OFFER.
    - Otherwise (not eligible): go to IDLE and drop the offer.
  - CLAIM: one cycle with no offer, so the controller can clear ip. Then go to IDLE.
- core_done_i with depth>0 pops the stack. With depth==0 it is ignored.
- core_done_i in the same cycle as an honoured core_ack_i: pop first, then push. Net depth is unchanged and the top is replaced.
- Stack overflow cannot occur because eligibility excludes the full state. Underflow is ignored as above.

## Timing
- Reset values: all outputs 0, state IDLE, depth 0, all stack entries cleared, miss_cnt_o 0.
- Offer latency: eligible sampled in cycle t gives core_irq_o=1 in cycle t+1 (registered).
- Claim: core_ack_i in cycle t gives edfic_ack_o as a one-cycle pulse in t+1, with nest_depth_o incremented in t+1.
- Re-offer: the earliest next core_irq_o is t+3, after the CLAIM cycle.
- Pop: core_done_i in cycle t gives the decremented nest_depth_o in t+1. The new top_rel is used from t+1.
- rst_i asserted mid-offer or mid-claim aborts the operation. No edfic_ack_o is issued after the reset edge.

## Configuration
- EDFIC_NEST_OVERRUN_EN defined:
  - When depth>0, the top entry has missed=0, and signed(top_rel) < 0, set missed=1 and pulse deadline_miss_o for one cycle (registered, one cycle after detection).
  - miss_cnt_o increments and saturates at 16'hFFFF.
  - Each entry reports at most once.
  - An overdue top still blocks any candidate whose signed relative deadline is not below top_rel.
- Not defined: deadline_miss_o=0 and miss_cnt_o=0 constant. No missed bits and no miss logic are synthesised.

## Test plan
- Single irq, empty stack: irq_valid_i=1, id=2, dl=100 → core_irq_o=1 next cycle. core_ack_i → edfic_ack_o pulse with edfic_id_o=2, depth 1.
- Preemption: running handler with dl=100 at mtime=0. At mtime=10, offer id=1 with dl=50 → offered. With dl=90 → not offered (top_rel=90, equality blocks). With dl=89 → offered.
- Stack full: StackDepth=2, two nested handlers, third earlier winner → no core_irq_o. After core_done_i → offered within 2 cycles.
- Offer replacement and withdrawal: in OFFER, winner switches to id=3 with an earlier dl → core_id_o=3 next cycle. irq_valid_i drops → core_irq_o=0 next cycle with no ack.
- Wrap-around: mtime lower bits at 2^DlWidth−20, dl=40 → abs wraps to 20 and top_rel=40. A later dl=30 winner preempts.
- Overrun (macro on): handler dl=5, mtime advances 6 → a single deadline_miss_o pulse and miss_cnt_o=1. Further cycles → no further pulse. core_done_i → depth 0.
